// File: rtl/count_sequence_checker_if.sv
// Bus between a counter-under-test harness and the sequence checker:
// sampled counter value and controls in, lock status and statistics out.
interface count_sequence_checker_if #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
);
  logic [WIDTH-1:0]      cnt_in;
  logic                  sample_en;
  logic                  clear;
  logic                  locked;
  logic                  err_pulse;
  logic                  wrap_pulse;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic [WIDTH-1:0]      bad_value;
  logic [WIDTH-1:0]      bad_expected;

  modport master (
    output cnt_in, sample_en, clear,
    input  locked, err_pulse, wrap_pulse, err_count, wrap_count, bad_value, bad_expected
  );

  modport slave (
    input  cnt_in, sample_en, clear,
    output locked, err_pulse, wrap_pulse, err_count, wrap_count, bad_value, bad_expected
  );
endinterface

// File: rtl/count_sequence_checker.sv
// Checks that each sampled counter value is the previous one plus one (mod 2^WIDTH),
// tracking lock, sequence errors and legal wraps with saturating/wrapping statistics.
module count_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_LEN   = 3,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  count_sequence_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [3:0] LockLen = 4'(LOCK_LEN);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic [3:0]            match_q, match_d;
  logic                  locked_q, locked_d;
  logic                  err_pulse_q, err_pulse_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0]      bad_value_q, bad_value_d;
  logic [WIDTH-1:0]      bad_expected_q, bad_expected_d;
  logic [WIDTH-1:0]      expected;
  logic                  in_seq;

  assign expected = WIDTH'(prev_q + 1'b1);
  assign in_seq   = (bus.cnt_in == expected);

  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    match_d        = match_q;
    err_pulse_d    = 1'b0;
    wrap_pulse_d   = 1'b0;
    err_count_d    = err_count_q;
    wrap_count_d   = wrap_count_q;
    bad_value_d    = bad_value_q;
    bad_expected_d = bad_expected_q;

    if (bus.sample_en) begin
      prev_d = bus.cnt_in;
      case (state_q)
        EMPTY: begin
          match_d = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (!in_seq) begin
            match_d = '0;
          end else if (match_q + 4'd1 == LockLen) begin
            match_d = '0;
            state_d = LOCKED;
          end else begin
            match_d = match_q + 4'd1;
          end
        end
        LOCKED: begin
          if (in_seq) begin
            if (prev_q == '1) begin
              wrap_pulse_d = 1'b1;
              wrap_count_d = wrap_count_q + 1'b1;
            end
          end else begin
            err_pulse_d    = 1'b1;
            err_count_d    = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
            bad_value_d    = bus.cnt_in;
            bad_expected_d = expected;
            match_d        = '0;
            state_d        = ACQUIRE;
          end
        end
        default: begin
          match_d = '0;
          state_d = EMPTY;
        end
      endcase
    end

    // clear beats a coincident error/wrap on the statistics, but the pulses still fire
    if (bus.clear) begin
      err_count_d    = '0;
      wrap_count_d   = '0;
      bad_value_d    = '0;
      bad_expected_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      prev_q         <= '0;
      match_q        <= '0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      err_count_q    <= '0;
      wrap_count_q   <= '0;
      bad_value_q    <= '0;
      bad_expected_q <= '0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      match_q        <= match_d;
      locked_q       <= locked_d;
      err_pulse_q    <= err_pulse_d;
      wrap_pulse_q   <= wrap_pulse_d;
      err_count_q    <= err_count_d;
      wrap_count_q   <= wrap_count_d;
      bad_value_q    <= bad_value_d;
      bad_expected_q <= bad_expected_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.err_pulse    = err_pulse_q;
  assign bus.wrap_pulse   = wrap_pulse_q;
  assign bus.err_count    = err_count_q;
  assign bus.wrap_count   = wrap_count_q;
  assign bus.bad_value    = bad_value_q;
  assign bus.bad_expected = bad_expected_q;

endmodule
